// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: sizing, data width and entry type encodings.
// Optional build macro used by this slice: ROB_BYPASS_EN (see rob_query.sv).
package rob_pkg;

  localparam int ROB_WIDTH = 3;
  localparam int ROB_SIZE  = 1 << ROB_WIDTH;
  localparam int DATA_W    = 32;
  localparam int RD_W      = 5;

  typedef enum logic [1:0] {
    ROB_TYPE_REG = 2'd0,
    ROB_TYPE_BR  = 2'd1,
    ROB_TYPE_ST  = 2'd2,
    ROB_TYPE_NOP = 2'd3
  } rob_type_e;

  localparam logic [ROB_WIDTH:0] ROB_FULL_COUNT = (ROB_WIDTH + 1)'(ROB_SIZE);

endpackage

// File: rtl/rob_query.sv
// Combinational operand lookup for one decoder source operand.
// ROB_BYPASS_EN: also forward a matching same-cycle broadcast (LSB over ALU).
module rob_query
  import rob_pkg::*;
(
  input  logic [ROB_WIDTH-1:0] query_id_i,
  input  logic [ROB_SIZE-1:0]  busy_i,
  input  logic [ROB_SIZE-1:0]  ready_i,
  input  logic [DATA_W-1:0]    value_i [ROB_SIZE],
`ifdef ROB_BYPASS_EN
  input  logic                 rs_valid_i,
  input  logic [ROB_WIDTH-1:0] rs_id_i,
  input  logic [DATA_W-1:0]    rs_value_i,
  input  logic                 lsb_valid_i,
  input  logic [ROB_WIDTH-1:0] lsb_id_i,
  input  logic [DATA_W-1:0]    lsb_value_i,
`endif
  output logic                 q_ready_o,
  output logic [DATA_W-1:0]    q_value_o
);

  always_comb begin
    q_ready_o = busy_i[query_id_i] && ready_i[query_id_i];
    q_value_o = value_i[query_id_i];
`ifdef ROB_BYPASS_EN
    if (busy_i[query_id_i]) begin
      if (lsb_valid_i && (lsb_id_i == query_id_i)) begin
        q_ready_o = 1'b1;
        q_value_o = lsb_value_i;
      end else if (rs_valid_i && (rs_id_i == query_id_i)) begin
        q_ready_o = 1'b1;
        q_value_o = rs_value_i;
      end
    end
`endif
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocation, out-of-order result capture, in-order commit
// with mispredict flush. Optional macro ROB_BYPASS_EN enables query forwarding.
module rob
  import rob_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  output logic                 rob_full,
  output logic [ROB_WIDTH-1:0] alloc_id,
  input  logic                 dec_ready,
  input  logic [1:0]           alloc_type,
  input  logic [RD_W-1:0]      alloc_rd,
  input  logic                 alloc_pred,
  input  logic [DATA_W-1:0]    alloc_alt_pc,
  input  logic                 rs_ready,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [DATA_W-1:0]    rs_value,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [DATA_W-1:0]    lsb_value,
  input  logic [ROB_WIDTH-1:0] query_j,
  input  logic [ROB_WIDTH-1:0] query_k,
  output logic                 qj_ready,
  output logic                 qk_ready,
  output logic [DATA_W-1:0]    qj_value,
  output logic [DATA_W-1:0]    qk_value,
  output logic                 commit_valid,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic [RD_W-1:0]      commit_rd,
  output logic [DATA_W-1:0]    commit_value,
  output logic                 commit_store,
  output logic                 clear,
  output logic [DATA_W-1:0]    clear_pc
);

  logic [ROB_SIZE-1:0]  busy_q;
  logic [ROB_SIZE-1:0]  ready_q;
  logic [ROB_SIZE-1:0]  pred_q;
  logic [DATA_W-1:0]    value_q  [ROB_SIZE];
  logic [DATA_W-1:0]    alt_pc_q [ROB_SIZE];
  logic [RD_W-1:0]      rd_q     [ROB_SIZE];
  rob_type_e            type_q   [ROB_SIZE];

  logic [ROB_WIDTH-1:0] head_q, head_d;
  logic [ROB_WIDTH-1:0] tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  logic                 commit_valid_q, commit_valid_d;
  logic [ROB_WIDTH-1:0] commit_rob_id_q, commit_rob_id_d;
  logic [RD_W-1:0]      commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0]    commit_value_q, commit_value_d;
  logic                 commit_store_q, commit_store_d;
  logic                 clear_q, clear_d;
  logic [DATA_W-1:0]    clear_pc_q, clear_pc_d;

  logic                 do_alloc;
  logic                 do_commit;
  logic                 mispredict;
  logic                 rs_hit;
  logic                 lsb_hit;
  rob_type_e            head_type;

  assign rob_full  = (count_q == ROB_FULL_COUNT);
  assign alloc_id  = tail_q;
  assign head_type = type_q[head_q];

  always_comb begin
    do_alloc   = dec_ready && !rob_full && !clear_q;
    do_commit  = busy_q[head_q] && ready_q[head_q] && !clear_q;
    mispredict = do_commit && (head_type == ROB_TYPE_BR) &&
                 (value_q[head_q][0] != pred_q[head_q]);
    rs_hit     = rs_ready && !clear_q && busy_q[rs_rob_id];
    lsb_hit    = lsb_ready && !clear_q && busy_q[lsb_rob_id];

    head_d  = head_q + ROB_WIDTH'(do_commit);
    tail_d  = tail_q + ROB_WIDTH'(do_alloc);
    count_d = count_q + (ROB_WIDTH + 1)'(do_alloc) - (ROB_WIDTH + 1)'(do_commit);

    commit_valid_d  = do_commit;
    commit_rob_id_d = commit_rob_id_q;
    commit_rd_d     = commit_rd_q;
    commit_value_d  = commit_value_q;
    commit_store_d  = 1'b0;
    clear_d         = mispredict;
    clear_pc_d      = clear_pc_q;

    if (do_commit) begin
      commit_rob_id_d = head_q;
      commit_rd_d     = (head_type == ROB_TYPE_REG) ? rd_q[head_q] : '0;
      commit_value_d  = value_q[head_q];
      commit_store_d  = (head_type == ROB_TYPE_ST);
    end
    if (mispredict) begin
      clear_pc_d = alt_pc_q[head_q];
    end

    // The flush cycle empties the queue; everything younger than the branch is gone.
    if (clear_q) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      busy_q          <= '0;
      ready_q         <= '0;
      commit_valid_q  <= 1'b0;
      commit_rob_id_q <= '0;
      commit_rd_q     <= '0;
      commit_value_q  <= '0;
      commit_store_q  <= 1'b0;
      clear_q         <= 1'b0;
      clear_pc_q      <= '0;
    end else if (rdy_in) begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      commit_valid_q  <= commit_valid_d;
      commit_rob_id_q <= commit_rob_id_d;
      commit_rd_q     <= commit_rd_d;
      commit_value_q  <= commit_value_d;
      commit_store_q  <= commit_store_d;
      clear_q         <= clear_d;
      clear_pc_q      <= clear_pc_d;
      if (clear_q) begin
        busy_q  <= '0;
        ready_q <= '0;
      end else begin
        if (do_alloc) begin
          busy_q[tail_q]   <= 1'b1;
          ready_q[tail_q]  <= (rob_type_e'(alloc_type) == ROB_TYPE_NOP);
          type_q[tail_q]   <= rob_type_e'(alloc_type);
          rd_q[tail_q]     <= alloc_rd;
          pred_q[tail_q]   <= alloc_pred;
          alt_pc_q[tail_q] <= alloc_alt_pc;
        end
        if (rs_hit) begin
          ready_q[rs_rob_id] <= 1'b1;
          value_q[rs_rob_id] <= rs_value;
        end
        // Written after the ALU update so the LSB wins on an id collision.
        if (lsb_hit) begin
          ready_q[lsb_rob_id] <= 1'b1;
          value_q[lsb_rob_id] <= lsb_value;
        end
        if (do_commit) begin
          busy_q[head_q] <= 1'b0;
        end
      end
    end
  end

  assign commit_valid  = commit_valid_q;
  assign commit_rob_id = commit_rob_id_q;
  assign commit_rd     = commit_rd_q;
  assign commit_value  = commit_value_q;
  assign commit_store  = commit_store_q;
  assign clear         = clear_q;
  assign clear_pc      = clear_pc_q;

`ifdef ROB_BYPASS_EN
  logic byp_rs_valid;
  logic byp_lsb_valid;
  assign byp_rs_valid  = rs_ready && !clear_q;
  assign byp_lsb_valid = lsb_ready && !clear_q;
`endif

  rob_query u_query_j (
    .query_id_i  (query_j),
    .busy_i      (busy_q),
    .ready_i     (ready_q),
    .value_i     (value_q),
`ifdef ROB_BYPASS_EN
    .rs_valid_i  (byp_rs_valid),
    .rs_id_i     (rs_rob_id),
    .rs_value_i  (rs_value),
    .lsb_valid_i (byp_lsb_valid),
    .lsb_id_i    (lsb_rob_id),
    .lsb_value_i (lsb_value),
`endif
    .q_ready_o   (qj_ready),
    .q_value_o   (qj_value)
  );

  rob_query u_query_k (
    .query_id_i  (query_k),
    .busy_i      (busy_q),
    .ready_i     (ready_q),
    .value_i     (value_q),
`ifdef ROB_BYPASS_EN
    .rs_valid_i  (byp_rs_valid),
    .rs_id_i     (rs_rob_id),
    .rs_value_i  (rs_value),
    .lsb_valid_i (byp_lsb_valid),
    .lsb_id_i    (lsb_rob_id),
    .lsb_value_i (lsb_value),
`endif
    .q_ready_o   (qk_ready),
    .q_value_o   (qk_value)
  );

endmodule

// File: tb/tb_rob.sv
// Directed testbench for the reorder buffer: allocation, capture, ordered commit,
// full handling, mispredict flush, stores, bus collisions and rdy_in stalls.
module tb_rob;
  import rob_pkg::*;

  logic                 clk;
  logic                 rst_in, rdy_in;
  logic                 rob_full;
  logic [ROB_WIDTH-1:0] alloc_id;
  logic                 dec_ready;
  logic [1:0]           alloc_type;
  logic [RD_W-1:0]      alloc_rd;
  logic                 alloc_pred;
  logic [DATA_W-1:0]    alloc_alt_pc;
  logic                 rs_ready, lsb_ready;
  logic [ROB_WIDTH-1:0] rs_rob_id, lsb_rob_id;
  logic [DATA_W-1:0]    rs_value, lsb_value;
  logic [ROB_WIDTH-1:0] query_j, query_k;
  logic                 qj_ready, qk_ready;
  logic [DATA_W-1:0]    qj_value, qk_value;
  logic                 commit_valid, commit_store, clear;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic [RD_W-1:0]      commit_rd;
  logic [DATA_W-1:0]    commit_value, clear_pc;

  int vectors = 0;
  int miscompares = 0;

  rob dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_full(rob_full), .alloc_id(alloc_id),
    .dec_ready(dec_ready), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pred(alloc_pred), .alloc_alt_pc(alloc_alt_pc),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .query_j(query_j), .query_k(query_k),
    .qj_ready(qj_ready), .qk_ready(qk_ready), .qj_value(qj_value), .qk_value(qk_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_store(commit_store),
    .clear(clear), .clear_pc(clear_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; dec_ready = 1'b0;
    alloc_type = ROB_TYPE_REG; alloc_rd = '0; alloc_pred = 1'b0; alloc_alt_pc = '0;
    rs_ready = 1'b0; rs_rob_id = '0; rs_value = '0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_value = '0;
    query_j = '0; query_k = '0;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic alloc(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                       input logic [31:0] alt);
    dec_ready = 1'b1; alloc_type = t; alloc_rd = rd; alloc_pred = pred; alloc_alt_pc = alt;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (rob_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %0d exp 0", rob_full); end
    vectors++; if (alloc_id !== 3'd0) begin miscompares++; $display("FAIL reset_alloc_id got %0d exp 0", alloc_id); end
    vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL reset_commit_valid got %0d exp 0", commit_valid); end
    vectors++; if (commit_value !== 32'h0) begin miscompares++; $display("FAIL reset_commit_value got %0h exp 0", commit_value); end
    vectors++; if (commit_rd !== 5'd0) begin miscompares++; $display("FAIL reset_commit_rd got %0d exp 0", commit_rd); end
    vectors++; if (commit_store !== 1'b0) begin miscompares++; $display("FAIL reset_commit_store got %0d exp 0", commit_store); end
    vectors++; if (clear !== 1'b0) begin miscompares++; $display("FAIL reset_clear got %0d exp 0", clear); end
    vectors++; if (clear_pc !== 32'h0) begin miscompares++; $display("FAIL reset_clear_pc got %0h exp 0", clear_pc); end
    vectors++; if (qj_ready !== 1'b0) begin miscompares++; $display("FAIL reset_qj_ready got %0d exp 0", qj_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    alloc(ROB_TYPE_REG, 5'd5, 1'b0, 32'h0);
    vectors++; if (alloc_id !== 3'd1) begin miscompares++; $display("FAIL basic_alloc_id got %0d exp 1", alloc_id); end
    query_j = 3'd0;
    #1;
    vectors++; if (qj_ready !== 1'b0) begin miscompares++; $display("FAIL basic_q_before got %0d exp 0", qj_ready); end
    rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h1234;
    tick();
    rs_ready = 1'b0;
    #1;
    vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL basic_no_early_commit got %0d exp 0", commit_valid); end
    vectors++; if (qj_ready !== 1'b1 || qj_value !== 32'h1234) begin miscompares++; $display("FAIL basic_query got %0d/%0h exp 1/1234", qj_ready, qj_value); end
    tick();
    vectors++; if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_value !== 32'h1234 || commit_rob_id !== 3'd0)
      begin miscompares++; $display("FAIL basic_commit got v%0d rd%0d val%0h id%0d exp v1 rd5 val1234 id0", commit_valid, commit_rd, commit_value, commit_rob_id); end
    tick();
    vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL basic_pulse got %0d exp 0", commit_valid); end
    $display("basic: REG rd5 id0 committed value 1234");
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) alloc(ROB_TYPE_REG, 5'(i + 1), 1'b0, 32'h0);
    vectors++; if (rob_full !== 1'b1 || alloc_id !== 3'd0) begin miscompares++; $display("FAIL full_after_fill got full%0d id%0d exp full1 id0", rob_full, alloc_id); end
    alloc(ROB_TYPE_REG, 5'd9, 1'b0, 32'h0);
    vectors++; if (rob_full !== 1'b1 || alloc_id !== 3'd0) begin miscompares++; $display("FAIL full_ignored_alloc got full%0d id%0d exp full1 id0", rob_full, alloc_id); end
    rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'hA0;
    tick();
    rs_ready = 1'b0;
    tick();
    vectors++; if (commit_valid !== 1'b1 || commit_rd !== 5'd1 || commit_value !== 32'hA0)
      begin miscompares++; $display("FAIL full_commit got v%0d rd%0d val%0h exp v1 rd1 valA0", commit_valid, commit_rd, commit_value); end
    vectors++; if (rob_full !== 1'b0 || alloc_id !== 3'd0) begin miscompares++; $display("FAIL full_after_commit got full%0d id%0d exp full0 id0", rob_full, alloc_id); end
    alloc(ROB_TYPE_REG, 5'd10, 1'b0, 32'h0);
    vectors++; if (rob_full !== 1'b1 || alloc_id !== 3'd1) begin miscompares++; $display("FAIL full_refill got full%0d id%0d exp full1 id1", rob_full, alloc_id); end
    $display("full: 8 entries, extra alloc ignored, wrap to id0");
  endtask

  task automatic test_out_of_order();
    logic [31:0] exp_val [3];
    exp_val[0] = 32'h30; exp_val[1] = 32'h11; exp_val[2] = 32'h22;
    do_reset();
    for (int i = 0; i < 3; i++) alloc(ROB_TYPE_REG, 5'(10 + i), 1'b0, 32'h0);
    for (int i = 2; i >= 0; i--) begin
      rs_ready = 1'b1; rs_rob_id = 3'(i); rs_value = exp_val[i];
      tick();
      vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_no_commit_%0d got %0d exp 0", i, commit_valid); end
    end
    rs_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (commit_valid !== 1'b1 || commit_rob_id !== 3'(i) || commit_rd !== 5'(10 + i) || commit_value !== exp_val[i])
        begin miscompares++; $display("FAIL ooo_commit_%0d got v%0d id%0d rd%0d val%0h exp v1 id%0d rd%0d val%0h", i, commit_valid, commit_rob_id, commit_rd, commit_value, i, 10 + i, exp_val[i]); end
      $display("ooo: commit id%0d value %0h", commit_rob_id, commit_value);
    end
    tick();
    vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_idle got %0d exp 0", commit_valid); end
  endtask

  task automatic test_branch();
    do_reset();
    alloc(ROB_TYPE_BR, 5'd7, 1'b0, 32'h100);
    alloc(ROB_TYPE_REG, 5'd3, 1'b0, 32'h0);
    rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h1;
    tick();
    rs_ready = 1'b0;
    vectors++; if (clear !== 1'b0) begin miscompares++; $display("FAIL br_clear_early got %0d exp 0", clear); end
    tick();
    vectors++; if (clear !== 1'b1 || clear_pc !== 32'h100) begin miscompares++; $display("FAIL br_clear got %0d pc %0h exp 1 pc 100", clear, clear_pc); end
    vectors++; if (commit_valid !== 1'b1 || commit_rd !== 5'd0 || commit_rob_id !== 3'd0)
      begin miscompares++; $display("FAIL br_commit got v%0d rd%0d id%0d exp v1 rd0 id0", commit_valid, commit_rd, commit_rob_id); end
    dec_ready = 1'b1; alloc_type = ROB_TYPE_REG; alloc_rd = 5'd4;
    rs_ready = 1'b1; rs_rob_id = 3'd1; rs_value = 32'h5;
    tick();
    dec_ready = 1'b0; rs_ready = 1'b0; query_j = 3'd1;
    #1;
    vectors++; if (clear !== 1'b0 || alloc_id !== 3'd0 || rob_full !== 1'b0 || commit_valid !== 1'b0)
      begin miscompares++; $display("FAIL br_flushed got clr%0d id%0d full%0d v%0d exp 0 0 0 0", clear, alloc_id, rob_full, commit_valid); end
    vectors++; if (qj_ready !== 1'b0) begin miscompares++; $display("FAIL br_entry_cleared got %0d exp 0", qj_ready); end
    $display("branch: mispredict flush to %0h", 32'h100);
    alloc(ROB_TYPE_BR, 5'd0, 1'b1, 32'h200);
    rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h1;
    tick();
    rs_ready = 1'b0;
    tick();
    vectors++; if (commit_valid !== 1'b1 || clear !== 1'b0 || commit_rd !== 5'd0)
      begin miscompares++; $display("FAIL br_match got v%0d clr%0d rd%0d exp v1 clr0 rd0", commit_valid, clear, commit_rd); end
    $display("branch: correct prediction, no flush");
  endtask

  task automatic test_store_nop();
    do_reset();
    alloc(ROB_TYPE_ST, 5'd5, 1'b0, 32'h0);
    lsb_ready = 1'b1; lsb_rob_id = 3'd0; lsb_value = 32'hDEAD;
    tick();
    lsb_ready = 1'b0;
    tick();
    vectors++; if (commit_valid !== 1'b1 || commit_store !== 1'b1 || commit_rd !== 5'd0)
      begin miscompares++; $display("FAIL store_commit got v%0d st%0d rd%0d exp v1 st1 rd0", commit_valid, commit_store, commit_rd); end
    tick();
    vectors++; if (commit_store !== 1'b0) begin miscompares++; $display("FAIL store_pulse got %0d exp 0", commit_store); end
    alloc(ROB_TYPE_NOP, 5'd6, 1'b0, 32'h0);
    vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL nop_early got %0d exp 0", commit_valid); end
    tick();
    vectors++; if (commit_valid !== 1'b1 || commit_rd !== 5'd0 || commit_rob_id !== 3'd1 || commit_store !== 1'b0)
      begin miscompares++; $display("FAIL nop_commit got v%0d rd%0d id%0d st%0d exp v1 rd0 id1 st0", commit_valid, commit_rd, commit_rob_id, commit_store); end
    $display("store/nop: store id0 and nop id1 retired");
  endtask

  task automatic test_same_id();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(ROB_TYPE_REG, 5'(20 + i), 1'b0, 32'h0);
    rs_ready = 1'b1; rs_rob_id = 3'd3; rs_value = 32'h7;
    lsb_ready = 1'b1; lsb_rob_id = 3'd3; lsb_value = 32'h9;
    tick();
    rs_rob_id = 3'd1; rs_value = 32'h11;
    lsb_rob_id = 3'd2; lsb_value = 32'h22;
    tick();
    lsb_ready = 1'b0;
    rs_rob_id = 3'd5; rs_value = 32'h55;
    tick();
    rs_ready = 1'b0;
    query_j = 3'd3; query_k = 3'd1;
    #1;
    vectors++; if (qj_ready !== 1'b1 || qj_value !== 32'h9) begin miscompares++; $display("FAIL same_id_lsb_wins got %0d/%0h exp 1/9", qj_ready, qj_value); end
    vectors++; if (qk_ready !== 1'b1 || qk_value !== 32'h11) begin miscompares++; $display("FAIL diff_id_rs got %0d/%0h exp 1/11", qk_ready, qk_value); end
    query_j = 3'd2; query_k = 3'd5;
    #1;
    vectors++; if (qj_ready !== 1'b1 || qj_value !== 32'h22) begin miscompares++; $display("FAIL diff_id_lsb got %0d/%0h exp 1/22", qj_ready, qj_value); end
    vectors++; if (qk_ready !== 1'b0) begin miscompares++; $display("FAIL not_busy_dropped got %0d exp 0", qk_ready); end
    vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL same_id_no_commit got %0d exp 0", commit_valid); end
    $display("same_id: collision on id3 resolved to 9");
  endtask

  task automatic test_rdy_low();
    do_reset();
    alloc(ROB_TYPE_REG, 5'd7, 1'b0, 32'h0);
    alloc(ROB_TYPE_REG, 5'd8, 1'b0, 32'h0);
    rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h70;
    lsb_ready = 1'b1; lsb_rob_id = 3'd1; lsb_value = 32'h80;
    tick();
    rs_ready = 1'b0; lsb_ready = 1'b0;
    vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL rdy_pre got %0d exp 0", commit_valid); end
    tick();
    vectors++; if (commit_valid !== 1'b1 || commit_rob_id !== 3'd0) begin miscompares++; $display("FAIL rdy_first got v%0d id%0d exp v1 id0", commit_valid, commit_rob_id); end
    rdy_in = 1'b0; dec_ready = 1'b1; alloc_type = ROB_TYPE_REG;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (commit_valid !== 1'b1 || commit_rob_id !== 3'd0 || commit_value !== 32'h70 || alloc_id !== 3'd2)
        begin miscompares++; $display("FAIL rdy_hold_%0d got v%0d id%0d val%0h tail%0d exp v1 id0 val70 tail2", i, commit_valid, commit_rob_id, commit_value, alloc_id); end
    end
    dec_ready = 1'b0; rdy_in = 1'b1;
    tick();
    vectors++; if (commit_valid !== 1'b1 || commit_rob_id !== 3'd1 || commit_rd !== 5'd8 || commit_value !== 32'h80)
      begin miscompares++; $display("FAIL rdy_resume got v%0d id%0d rd%0d val%0h exp v1 id1 rd8 val80", commit_valid, commit_rob_id, commit_rd, commit_value); end
    tick();
    vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL rdy_idle got %0d exp 0", commit_valid); end
    $display("rdy_low: 3-cycle stall held outputs, resumed with id1");
  endtask

  task automatic test_reset_override();
    do_reset();
    alloc(ROB_TYPE_REG, 5'd2, 1'b0, 32'h0);
    rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h42;
    tick();
    rs_ready = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    vectors++; if (commit_valid !== 1'b0 || commit_value !== 32'h0 || alloc_id !== 3'd0)
      begin miscompares++; $display("FAIL reset_override got v%0d val%0h id%0d exp 0 0 0", commit_valid, commit_value, alloc_id); end
    $display("reset_override: pending commit discarded");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_out_of_order();
    test_branch();
    test_store_nop();
    test_same_id();
    test_rdy_low();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
